// File: rtl/tx_frame_scheduler.sv
// Frame sequencer for the TX bit stream: preamble, sync word, length header,
// payload bits fetched from a byte source, then an idle gap of zeros.
module tx_frame_scheduler #(
    parameter int                PREAMBLE_LEN = 32,
    parameter int                SYNC_LEN     = 16,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD  = 16'hD391,
    parameter int                GAP_LEN      = 64,
    parameter int                CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_req,
    input  logic [7:0] frame_len,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic       out_data,
    input  logic       out_ready
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        SYNC     = 3'd2,
        HEADER   = 3'd3,
        PAYLOAD  = 3'd4,
        GAP      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [7:0]          len_r;
    logic [7:0]          fetched_r;
    logic [7:0]          loaded_r;
    logic [7:0]          buf_r;
    logic                buf_full_r;
    logic [7:0]          sh_r;
    logic                sh_valid_r;
    logic [SYNC_LEN-1:0] sync_r;
    logic                underrun_r;

    logic out_valid_s, out_data_s, frame_done_s, accept_s;
    logic in_ready_s, bit_fire_s, byte_fire_s, boundary_s, load_s;

    // Next-state decode and bit-stream outputs
    always_comb begin
        state_s      = state_r;
        out_valid_s  = 1'b0;
        out_data_s   = 1'b0;
        frame_done_s = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (frame_req) begin
                    accept_s = 1'b1;
                    state_s  = PREAMBLE;
                end else begin
                    state_s  = IDLE;
                end
            end
            PREAMBLE: begin
                out_valid_s = 1'b1;
                out_data_s  = ~cnt_r[0];
                if (out_ready && (cnt_r == PRE_LAST)) begin
                    state_s = SYNC;
                end else begin
                    state_s = PREAMBLE;
                end
            end
            SYNC: begin
                out_valid_s = 1'b1;
                out_data_s  = sync_r[SYNC_LEN-1];
                if (out_ready && (cnt_r == SYNC_LAST)) begin
                    state_s = HEADER;
                end else begin
                    state_s = SYNC;
                end
            end
            HEADER: begin
                out_valid_s = 1'b1;
                out_data_s  = sh_r[7];
                if (out_ready && (cnt_r == BYTE_LAST)) begin
                    state_s = (len_r == 8'd0) ? GAP : PAYLOAD;
                end else begin
                    state_s = HEADER;
                end
            end
            PAYLOAD: begin
                // Output is withheld while the shifter waits for a late byte
                out_valid_s = sh_valid_r;
                out_data_s  = sh_r[7];
                if (out_ready && sh_valid_r && (cnt_r == BYTE_LAST) && (loaded_r == len_r)) begin
                    state_s = GAP;
                end else begin
                    state_s = PAYLOAD;
                end
            end
            GAP: begin
                out_valid_s = 1'b1;
                out_data_s  = 1'b0;
                if (out_ready && (cnt_r == GAP_LAST)) begin
                    state_s      = IDLE;
                    frame_done_s = 1'b1;
                end else begin
                    state_s = GAP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Handshake and byte-boundary control decode
    always_comb begin
        in_ready_s  = 1'b0;
        bit_fire_s  = 1'b0;
        byte_fire_s = 1'b0;
        boundary_s  = 1'b0;
        load_s      = 1'b0;
        if (((state_r == HEADER) || (state_r == PAYLOAD)) && !buf_full_r && (fetched_r < len_r)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        bit_fire_s  = out_valid_s && out_ready;
        byte_fire_s = in_valid && in_ready_s;
        boundary_s  = bit_fire_s && (cnt_r == BYTE_LAST) &&
                      (((state_r == HEADER) && (len_r != 8'd0)) ||
                       ((state_r == PAYLOAD) && (loaded_r != len_r)));
        load_s      = buf_full_r && (boundary_s || ((state_r == PAYLOAD) && !sh_valid_r));
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Counters, byte buffer, shifters and sticky underrun flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r      <= '0;
            len_r      <= 8'd0;
            fetched_r  <= 8'd0;
            loaded_r   <= 8'd0;
            buf_r      <= 8'd0;
            buf_full_r <= 1'b0;
            sh_r       <= 8'd0;
            sh_valid_r <= 1'b0;
            sync_r     <= '0;
            underrun_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r      <= '0;
            len_r      <= frame_len;
            fetched_r  <= 8'd0;
            loaded_r   <= 8'd0;
            buf_full_r <= 1'b0;
            sh_valid_r <= 1'b0;
            sync_r     <= SYNC_WORD;
            underrun_r <= 1'b0;
        end else begin
            if (bit_fire_s) begin
                if ((state_s != state_r) || ((state_r == PAYLOAD) && (cnt_r == BYTE_LAST))) begin
                    cnt_r <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_ONE;
                end
            end
            if (bit_fire_s && (state_r == SYNC)) begin
                sync_r <= {sync_r[SYNC_LEN-2:0], 1'b0};
            end
            // The header reuses the payload shifter so both leave MSB first
            if ((state_r == SYNC) && (state_s == HEADER)) begin
                sh_r <= len_r;
            end else if (load_s) begin
                sh_r <= buf_r;
            end else if (bit_fire_s && ((state_r == HEADER) || (state_r == PAYLOAD))) begin
                sh_r <= {sh_r[6:0], 1'b0};
            end
            if (load_s) begin
                sh_valid_r <= 1'b1;
                loaded_r   <= loaded_r + 8'd1;
            end else if (bit_fire_s && (cnt_r == BYTE_LAST) &&
                         ((state_r == HEADER) || (state_r == PAYLOAD))) begin
                sh_valid_r <= 1'b0;
            end
            if (byte_fire_s) begin
                buf_r      <= in_data;
                buf_full_r <= 1'b1;
                fetched_r  <= fetched_r + 8'd1;
            end else if (load_s) begin
                buf_full_r <= 1'b0;
            end
            if ((state_r == PAYLOAD) && !sh_valid_r) begin
                underrun_r <= 1'b1;
            end
        end
    end

    assign busy       = (state_r != IDLE);
    assign frame_done = frame_done_s;
    assign underrun   = underrun_r;
    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_s;
    assign out_data   = out_data_s;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed self-checking bench for tx_frame_scheduler: frames are captured bit
// by bit and compared against a sequence built from the frame layout.
module tb_tx_frame_scheduler;

    logic       clk;
    logic       rst;
    logic       frame_req;
    logic [7:0] frame_len;
    logic       busy, frame_done, underrun;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid, out_data, out_ready;

    tx_frame_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .frame_req  (frame_req),
        .frame_len  (frame_len),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   tests_run = 0;
    int   tests_failed = 0;
    bit   got_q[$];
    bit   exp_q[$];
    logic [7:0] byt [0:2];
    int   n_done, done_at, stall_cyc, rdy_cnt, unstable, fetched_n;

    task automatic check_eq(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic build_exp(input int len);
        logic [15:0] sw;
        logic [7:0]  lb;
        sw = 16'hD391;
        lb = len[7:0];
        exp_q.delete();
        for (int k = 0; k < 32; k++) exp_q.push_back((k % 2) == 0);
        for (int k = 0; k < 16; k++) exp_q.push_back(sw[15-k]);
        for (int k = 0; k < 8; k++) exp_q.push_back(lb[7-k]);
        for (int b = 0; b < len; b++)
            for (int k = 0; k < 8; k++) exp_q.push_back(byt[b][7-k]);
        for (int k = 0; k < 64; k++) exp_q.push_back(1'b0);
    endtask

    task automatic compare_bits(input string tag);
        int errs;
        int n;
        errs = 0;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (got_q[i] != exp_q[i]) errs++;
        check_eq({tag, "_bit_errs"}, errs, 0);
        check_eq({tag, "_nbits"}, got_q.size(), exp_q.size());
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq(tag, int'({busy, frame_done, underrun, in_ready, out_valid, out_data}), 0);
    endtask

    // Runs one frame; inputs change 1 time unit after posedge, outputs sampled 3 after
    task automatic run_frame(input int len, input bit rnd_ready, input int hold_idx,
                             input int hold_cyc, input int midreq_bit, input int abort_bit);
        int  idx, hold_cnt, post;
        bit  first, fin, mid_sent, prev_stall, prev_data;
        got_q.delete();
        n_done = 0; done_at = -1; stall_cyc = 0; rdy_cnt = 0; unstable = 0;
        idx = 0; hold_cnt = 0; post = 0; first = 1'b1; fin = 1'b0; mid_sent = 1'b0;
        prev_stall = 1'b0; prev_data = 1'b0;
        @(posedge clk); #1;
        frame_req = 1'b1; frame_len = len[7:0];
        @(posedge clk); #1;
        frame_req = 1'b0;
        for (int c = 0; c < 4000 && !fin; c++) begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx == hold_idx && hold_cnt < hold_cyc) begin
                in_valid = 1'b0;
                hold_cnt++;
            end else begin
                in_valid = 1'b1;
                in_data  = (idx < len) ? byt[idx] : 8'hEE;
            end
            if (midreq_bit >= 0 && !mid_sent && got_q.size() >= midreq_bit) begin
                frame_req = 1'b1; frame_len = 8'd9; mid_sent = 1'b1;
            end else begin
                frame_req = 1'b0;
            end
            if (abort_bit >= 0 && got_q.size() >= abort_bit) begin
                rst = 1'b1;
                #1;
                check_reset_outs("abort_rst_outs");
                @(posedge clk); #1;
                rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
                return;
            end
            #2;
            if (first) begin
                check_eq("first_valid", out_valid, 1);
                check_eq("first_bit", out_data, 1);
                first = 1'b0;
            end
            if (prev_stall && out_data != prev_data) unstable++;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_ready) rdy_cnt++;
            if (in_valid && in_ready) idx++;
            if (busy && !out_valid) stall_cyc++;
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (frame_done) begin
                n_done++;
                done_at = got_q.size();
            end
            if (n_done > 0) post++;
            if (post == 2) check_eq("busy_drop", busy, 0);
            if (post == 12) fin = 1'b1;
            @(posedge clk); #1;
        end
        if (!fin) check_eq("frame_timeout", 0, 1);
        in_valid = 1'b0; frame_req = 1'b0; out_ready = 1'b1;
        fetched_n = idx;
    endtask

    initial begin
        rst = 1'b1; frame_req = 1'b0; frame_len = 8'd0;
        in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
        #12;
        check_reset_outs("reset_outs");
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic two-byte frame
        byt[0] = 8'hA5; byt[1] = 8'h3C; byt[2] = 8'h00;
        build_exp(2);
        run_frame(2, 1'b0, -1, 0, -1, -1);
        compare_bits("t1");
        check_eq("t1_done_at", done_at, 136);
        check_eq("t1_ndone", n_done, 1);
        check_eq("t1_underrun", underrun, 0);
        check_eq("t1_fetched", fetched_n, 2);
        check_eq("t1_stall", stall_cyc, 0);

        // Same frame under random backpressure
        run_frame(2, 1'b1, -1, 0, -1, -1);
        compare_bits("t2");
        check_eq("t2_unstable", unstable, 0);
        check_eq("t2_ndone", n_done, 1);

        // Source withholds the second byte
        byt[0] = 8'h81; byt[1] = 8'h5A; byt[2] = 8'hC3;
        build_exp(3);
        run_frame(3, 1'b0, 1, 30, -1, -1);
        compare_bits("t3");
        check_eq("t3_underrun", underrun, 1);
        check_eq("t3_stalled", int'(stall_cyc > 0), 1);
        check_eq("t3_ndone", n_done, 1);

        // Empty payload; underrun must have cleared at acceptance
        build_exp(0);
        run_frame(0, 1'b0, -1, 0, -1, -1);
        compare_bits("t4");
        check_eq("t4_ready_pulses", rdy_cnt, 0);
        check_eq("t4_underrun", underrun, 0);
        check_eq("t4_done_at", done_at, 120);

        // Request during payload is ignored
        byt[0] = 8'hA5; byt[1] = 8'h3C;
        build_exp(2);
        run_frame(2, 1'b0, -1, 0, 60, -1);
        compare_bits("t5");
        check_eq("t5_ndone", n_done, 1);
        check_eq("t5_fetched", fetched_n, 2);

        // Reset during sync, then a clean one-byte frame
        run_frame(1, 1'b0, -1, 0, -1, 40);
        check_eq("t6_abort_ndone", n_done, 0);
        byt[0] = 8'hFF;
        build_exp(1);
        run_frame(1, 1'b0, -1, 0, -1, -1);
        compare_bits("t6");
        check_eq("t6_done_at", done_at, 128);
        check_eq("t6_ndone", n_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
